// File: rtl/xpushs_bank.sv
// xpushs_bank: N-channel push-button front end (sync, debounce, press capture with valid/ack).
// Define XPUSHS_AUTOREPEAT_EN to add periodic repeat events while a button is held.
module xpushs_bank #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic [N_BTN-1:0] btn_in,
    input  logic             ack,
    output logic             valid,
    output logic [N_BTN-1:0] data_out,
    output logic [N_BTN-1:0] btn_state
);

    localparam int            DW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] s1;
    logic [N_BTN-1:0] s2;
    logic [N_BTN-1:0] stable;
    logic [N_BTN-1:0] stable_d;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] pending;
    logic [DW-1:0]    db_cnt [N_BTN];
    logic             clr;

    if (N_BTN < 1 || N_BTN > 16) begin : g_bad_n_btn
        $error("xpushs_bank: N_BTN must be in 1..16");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("xpushs_bank: DEBOUNCE_CYCLES must be >= 2");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
        $error("xpushs_bank: REPEAT_CYCLES must be >= 2");
    end

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1       <= '0;
            s2       <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            s1       <= btn_in;
            s2       <= s1;
            stable_d <= stable;
            for (int i = 0; i < N_BTN; i++) begin
                if (s2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise = stable & ~stable_d;

`ifdef XPUSHS_AUTOREPEAT_EN
    localparam int            RW       = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0]    rpt_cnt [N_BTN];
    logic [N_BTN-1:0] rpt_fire;

    always_comb begin
        rpt_fire = '0;
        for (int i = 0; i < N_BTN; i++) begin
            rpt_fire[i] = (rpt_cnt[i] == RPT_LAST);
        end
    end

    assign press = rise | rpt_fire;

    // Hold timer restarts on every event of its channel, so repeats are evenly spaced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                rpt_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (!stable[i] || press[i]) begin
                    rpt_cnt[i] <= '0;
                end else begin
                    rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign press = rise;
`endif

    // New events are OR-ed in after the clear, so a press never gets lost to a concurrent ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~{N_BTN{clr}}) | press;
        end
    end

    assign clr       = sel & ack & valid;
    assign valid     = |pending;
    assign data_out  = sel ? pending : '0;
    assign btn_state = stable;

endmodule

// File: tb/tb_xpushs_bank.sv
// Self-checking bench for xpushs_bank: directed scenarios plus randomized traffic
// compared against a window-based behavioural model of debounce and press capture.
module tb_xpushs_bank;

    localparam int NB = 4;
    localparam int D  = 4;
    localparam int R  = 8;

    logic          clk;
    logic          rst;
    logic          sel;
    logic          ack;
    logic [NB-1:0] btn_in;
    logic          valid;
    logic [NB-1:0] data_out;
    logic [NB-1:0] btn_state;

    int checks   = 0;
    int failures = 0;

    logic [NB-1:0] hist [$];
    logic [NB-1:0] m_stable;
    logic [NB-1:0] m_ev;
    logic [NB-1:0] m_pending;
    int            m_age [NB];

    xpushs_bank #(
        .N_BTN(NB),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_CYCLES(R)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sel(sel),
        .btn_in(btn_in),
        .ack(ack),
        .valid(valid),
        .data_out(data_out),
        .btn_state(btn_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a level is accepted once the last D synchronised samples all oppose it.
    initial begin : model
        logic [NB-1:0] nxt_stable;
        logic [NB-1:0] nxt_ev;
        logic          clr;
        logic          flip;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                hist.delete();
                for (int j = 0; j < D + 2; j++) hist.push_back(NB'(0));
                m_stable  = '0;
                m_ev      = '0;
                m_pending = '0;
                for (int i = 0; i < NB; i++) m_age[i] = 0;
            end else begin
                clr       = sel && ack && (m_pending != '0);
                m_pending = (m_pending & ~{NB{clr}}) | m_ev;
                hist.push_front(btn_in);
                void'(hist.pop_back());
                nxt_stable = m_stable;
                for (int i = 0; i < NB; i++) begin
                    flip = 1'b1;
                    for (int j = 2; j <= D + 1; j++) begin
                        if (hist[j][i] == m_stable[i]) flip = 1'b0;
                    end
                    if (flip) nxt_stable[i] = ~m_stable[i];
                end
                nxt_ev = nxt_stable & ~m_stable;
`ifdef XPUSHS_AUTOREPEAT_EN
                for (int i = 0; i < NB; i++) begin
                    if (!m_stable[i] || m_ev[i]) m_age[i] = 0;
                    else m_age[i] = m_age[i] + 1;
                    if (m_age[i] == R - 1) nxt_ev[i] = 1'b1;
                end
`endif
                m_stable = nxt_stable;
                m_ev     = nxt_ev;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        sel = 1'b1;
        checks++;
        if ({valid, data_out, btn_state} !== 9'b0) begin
            failures++;
            $display("[TB] FAIL reset_initial: got valid=%b data=%b state=%b expected all zero", valid, data_out, btn_state);
        end
        btn_in = 4'b1111;
        for (int n = 0; n < 20 && valid !== 1'b1; n++) tick;
        checks++;
        if (valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_wait_valid: got valid=%b expected 1 within 20 cycles", valid);
        end
        tick;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({valid, data_out, btn_state} !== 9'b0) begin
            failures++;
            $display("[TB] FAIL reset_async: got valid=%b data=%b state=%b expected all zero", valid, data_out, btn_state);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            tick;
            checks++;
            if (valid !== (n == 7)) begin
                failures++;
                $display("[TB] FAIL reset_requalify edge %0d: got valid=%b expected %b", n, valid, (n == 7));
            end
        end
        checks++;
        if (data_out !== 4'b1111) begin
            failures++;
            $display("[TB] FAIL reset_requalify_mask: got %b expected 1111", data_out);
        end
        btn_in = '0;
        ack    = 1'b1;
        tick;
        ack = 1'b0;
        repeat (10) tick;
        checks++;
        if ({valid, btn_state} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_cleanup: got valid=%b state=%b expected 0", valid, btn_state);
        end
    endtask

    task automatic test_clean_press;
        btn_in = 4'b0100;
        for (int n = 1; n <= 7; n++) begin
            tick;
            checks++;
            if (btn_state !== ((n >= 6) ? 4'b0100 : 4'b0000)) begin
                failures++;
                $display("[TB] FAIL press_state edge %0d: got %b", n, btn_state);
            end
            if (n == 6) begin
                checks++;
                if (valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL press_early_valid: got %b expected 0", valid);
                end
            end
        end
        checks++;
        if (valid !== 1'b1 || data_out !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL press_event: got valid=%b data=%b expected 1 0100", valid, data_out);
        end
        sel = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b1 || data_out !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL press_sel_gate: got valid=%b data=%b expected 1 0000", valid, data_out);
        end
        sel    = 1'b1;
        ack    = 1'b1;
        btn_in = '0;
        tick;
        ack = 1'b0;
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL press_ack_clear: got valid=%b expected 0", valid);
        end
        repeat (10) tick;
    endtask

    task automatic test_bounce;
        bit [6:0] seq;
        seq = 7'b1111011;
        for (int n = 1; n <= 10; n++) begin
            btn_in = {3'b000, (n <= 7) ? seq[n-1] : 1'b1};
            tick;
            checks++;
            if (btn_state[0] !== (n >= 9) || valid !== (n >= 10)) begin
                failures++;
                $display("[TB] FAIL bounce edge %0d: got state=%b valid=%b expected %b %b", n, btn_state[0], valid, (n >= 9), (n >= 10));
            end
        end
        checks++;
        if (data_out !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL bounce_mask: got %b expected 0001", data_out);
        end
        ack    = 1'b1;
        btn_in = '0;
        tick;
        ack = 1'b0;
        repeat (10) tick;
        for (int n = 1; n <= 18; n++) begin
            btn_in = (n <= 3) ? 4'b0001 : 4'b0000;
            tick;
            checks++;
            if ({valid, btn_state} !== 5'b0) begin
                failures++;
                $display("[TB] FAIL glitch cycle %0d: got valid=%b state=%b expected 0", n, valid, btn_state);
            end
        end
    endtask

    task automatic test_race;
        for (int n = 1; n <= 9; n++) begin
            btn_in = {(n >= 3), 2'b00, (n <= 6)};
            ack    = (n == 9);
            tick;
            if (n == 7 || n == 8) begin
                checks++;
                if (data_out !== 4'b0001) begin
                    failures++;
                    $display("[TB] FAIL race_setup edge %0d: got %b expected 0001", n, data_out);
                end
            end
        end
        checks++;
        if (valid !== 1'b1 || data_out !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL race_event_wins: got valid=%b data=%b expected 1 1000", valid, data_out);
        end
        btn_in = '0;
        sel    = 1'b0;
        ack    = 1'b1;
        tick;
        sel = 1'b1;
        ack = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b1 || data_out !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL race_ack_unselected: got valid=%b data=%b expected 1 1000", valid, data_out);
        end
        ack = 1'b1;
        tick;
        ack = 1'b0;
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL race_final_clear: got valid=%b expected 0", valid);
        end
        repeat (10) tick;
    endtask

    task automatic test_simultaneous;
        btn_in = 4'b1010;
        for (int n = 1; n <= 7; n++) begin
            tick;
            if (n == 6) begin
                checks++;
                if (valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL simul_early: got valid=%b expected 0", valid);
                end
            end
        end
        checks++;
        if (data_out !== 4'b1010) begin
            failures++;
            $display("[TB] FAIL simul_mask: got %b expected 1010", data_out);
        end
        ack    = 1'b1;
        btn_in = '0;
        tick;
        ack = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            tick;
            checks++;
            if (valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL simul_release cycle %0d: got valid=%b expected 0", n, valid);
            end
        end
    endtask

    task automatic test_hold;
        logic exp;
        btn_in = 4'b0010;
        repeat (7) tick;
        checks++;
        if (data_out !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL hold_first: got %b expected 0010", data_out);
        end
        ack = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            tick;
`ifdef XPUSHS_AUTOREPEAT_EN
            exp = (n % R == 0);
`else
            exp = 1'b0;
`endif
            checks++;
            if (valid !== exp) begin
                failures++;
                $display("[TB] FAIL hold cycle %0d: got valid=%b expected %b", n, valid, exp);
            end
        end
        btn_in = '0;
        repeat (12) tick;
        ack = 1'b0;
        tick;
        checks++;
        if ({valid, btn_state} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL hold_release: got valid=%b state=%b expected 0", valid, btn_state);
        end
    endtask

    task automatic test_random;
        logic [NB-1:0] lv;
        lv = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(5) == 0) lv[i] = ~lv[i];
            end
            btn_in = lv;
            sel    = ($urandom_range(3) != 0);
            ack    = ($urandom_range(3) == 0);
            if (c == 200) begin
                rst = 1'b1;
                #2;
                rst = 1'b0;
            end
            tick;
            checks++;
            if (btn_state !== m_stable) begin
                failures++;
                $display("[TB] FAIL random_state cycle %0d: got %b expected %b", c, btn_state, m_stable);
            end
            checks++;
            if (valid !== (m_pending != '0)) begin
                failures++;
                $display("[TB] FAIL random_valid cycle %0d: got %b expected %b", c, valid, (m_pending != '0));
            end
            checks++;
            if (data_out !== (sel ? m_pending : 4'b0000)) begin
                failures++;
                $display("[TB] FAIL random_data cycle %0d: got %b expected %b", c, data_out, (sel ? m_pending : 4'b0000));
            end
        end
        btn_in = '0;
        ack    = 1'b0;
        sel    = 1'b1;
    endtask

    initial begin
        rst    = 1'b1;
        sel    = 1'b0;
        ack    = 1'b0;
        btn_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset;
        test_clean_press;
        test_bounce;
        test_race;
        test_simultaneous;
        test_hold;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
